// File: rtl/program_loader.sv
// program_loader: byte-stream boot loader that writes 16-bit words into
// program memory and keeps the CPU halted until a frame checks good.
// Frame: ADDR_HI ADDR_LO CNT_HI CNT_LO {DATA_HI DATA_LO} x N CSUM, where the
// mod-256 sum of every byte, CSUM included, must come out to zero.
module program_loader #(
  parameter int unsigned TIMEOUT       = 65535,
  parameter bit          HALT_ON_RESET = 1'b1
) (
  input  logic        i_CLOCK,
  input  logic        i_RESET,
  input  logic        i_START,
  input  logic [7:0]  i_BYTE,
  input  logic        i_VALID,
  output logic        o_READY,
  output logic [15:0] o_MEMWADDR,
  output logic [15:0] o_MEMWDATA,
  output logic        f_MEMWRITE,
  output logic        o_HALT,
  output logic        o_BUSY,
  output logic        o_DONE,
  output logic        o_ERROR
);

  // Idle counter is sized to hold TIMEOUT itself; it stays at zero when the
  // timeout is disabled.
  localparam int TO_W = $clog2(TIMEOUT + 2);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    CNT_HI,
    CNT_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    CSUM,
    DONE,
    ERROR
  } state_t;

  state_t state_q, state_d;
  logic ready_q, ready_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic error_q, error_d;
  logic halt_q, halt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [7:0] dataHi_q, dataHi_d;
  logic [15:0] count_q, count_d;
  logic [7:0] sum_q, sum_d;
  logic [TO_W-1:0] toCount_q, toCount_d;

  logic accept;
  logic [7:0] sumNext;
  logic [15:0] cntNext;

  // States in which the loader is waiting for a stream byte.
  function automatic logic isReceiving(input state_t s);
    return (s == ADDR_HI) || (s == ADDR_LO) || (s == CNT_HI) ||
           (s == CNT_LO) || (s == DATA_HI) || (s == DATA_LO) || (s == CSUM);
  endfunction

  assign accept  = i_VALID && ready_q;
  assign sumNext = sum_q + i_BYTE;
  assign cntNext = {count_q[15:8], i_BYTE};

  // Next-state and datapath updates; the timeout check sits after the main
  // case so it can override a receiving state that saw no byte.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    dataHi_d  = dataHi_q;
    count_d   = count_q;
    sum_d     = sum_q;
    done_d    = done_q;
    error_d   = error_q;
    halt_d    = halt_q;
    toCount_d = toCount_q;

    if (accept) begin
      sum_d = sumNext;
    end

    case (state_q)
      IDLE: begin
        if (i_START) begin
          sum_d     = 8'd0;
          done_d    = 1'b0;
          error_d   = 1'b0;
          halt_d    = 1'b1;
          toCount_d = '0;
          state_d   = ADDR_HI;
        end
      end
      ADDR_HI: begin
        if (accept) begin
          addr_d[15:8] = i_BYTE;
          state_d      = ADDR_LO;
        end
      end
      ADDR_LO: begin
        if (accept) begin
          addr_d[7:0] = i_BYTE;
          state_d     = CNT_HI;
        end
      end
      CNT_HI: begin
        if (accept) begin
          count_d[15:8] = i_BYTE;
          state_d       = CNT_LO;
        end
      end
      CNT_LO: begin
        if (accept) begin
          count_d = cntNext;
          state_d = (cntNext != 16'd0) ? DATA_HI : CSUM;
        end
      end
      DATA_HI: begin
        if (accept) begin
          dataHi_d = i_BYTE;
          state_d  = DATA_LO;
        end
      end
      DATA_LO: begin
        if (accept) begin
          wdata_d = {dataHi_q, i_BYTE};
          state_d = WRITE;
        end
      end
      WRITE: begin
        addr_d  = addr_q + 16'd1;
        count_d = count_q - 16'd1;
        state_d = (count_q == 16'd1) ? CSUM : DATA_HI;
      end
      CSUM: begin
        if (accept) begin
          if (sumNext == 8'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
            halt_d  = 1'b0;
          end else begin
            state_d = ERROR;
            error_d = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if ((TIMEOUT != 0) && isReceiving(state_q)) begin
      if (accept) begin
        toCount_d = '0;
      end else if (toCount_q == TO_LAST) begin
        toCount_d = '0;
        state_d   = ERROR;
        error_d   = 1'b1;
      end else begin
        toCount_d = toCount_q + TO_W'(1);
      end
    end else begin
      toCount_d = '0;
    end
  end

  // Ready and busy are registered decodes of the state being entered.
  always_comb begin
    ready_d = isReceiving(state_d);
    busy_d  = (state_d != IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_CLOCK) begin
    if (i_RESET) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      halt_q    <= HALT_ON_RESET;
      addr_q    <= 16'd0;
      wdata_q   <= 16'd0;
      dataHi_q  <= 8'd0;
      count_q   <= 16'd0;
      sum_q     <= 8'd0;
      toCount_q <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      halt_q    <= halt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      dataHi_q  <= dataHi_d;
      count_q   <= count_d;
      sum_q     <= sum_d;
      toCount_q <= toCount_d;
    end
  end

  assign o_READY    = ready_q;
  assign o_BUSY     = busy_q;
  assign o_DONE     = done_q;
  assign o_ERROR    = error_q;
  assign o_HALT     = halt_q;
  assign o_MEMWADDR = addr_q;
  assign o_MEMWDATA = wdata_q;
  assign f_MEMWRITE = (state_q == WRITE);

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: drives framed byte streams into program_loader and
// compares memory writes and status flags against a frame-level model.
module tb_program_loader;

  localparam int TIMEOUT = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byteIn = 8'd0;
  logic        valid = 1'b0;
  logic        ready;
  logic [15:0] memWaddr;
  logic [15:0] memWdata;
  logic        memWrite;
  logic        halt;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int failures = 0;

  logic [7:0]  frameBytes[$];
  logic [15:0] wordsIn[$];
  logic [15:0] expAddr[$];
  logic [15:0] expData[$];
  bit          expOk;

  logic [15:0] gotAddr[$];
  logic [15:0] gotData[$];
  int          readyDuringWrite = 0;

  program_loader #(.TIMEOUT(TIMEOUT), .HALT_ON_RESET(1'b1)) dut (
    .i_CLOCK(clock),
    .i_RESET(reset),
    .i_START(start),
    .i_BYTE(byteIn),
    .i_VALID(valid),
    .o_READY(ready),
    .o_MEMWADDR(memWaddr),
    .o_MEMWDATA(memWdata),
    .f_MEMWRITE(memWrite),
    .o_HALT(halt),
    .o_BUSY(busy),
    .o_DONE(done),
    .o_ERROR(error)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  // Record every write strobe seen on the memory port.
  always @(negedge clock) begin
    if (memWrite === 1'b1) begin
      gotAddr.push_back(memWaddr);
      gotData.push_back(memWdata);
      if (ready !== 1'b0) readyDuringWrite++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Frame model: byte list, checksum and the writes a good loader performs.
  task automatic buildFrame(input logic [15:0] addr, input bit corrupt);
    int sum;
    logic [15:0] n;
    logic [7:0] csum;
    n = 16'(wordsIn.size());
    frameBytes.delete();
    expAddr.delete();
    expData.delete();
    frameBytes.push_back(addr[15:8]);
    frameBytes.push_back(addr[7:0]);
    frameBytes.push_back(n[15:8]);
    frameBytes.push_back(n[7:0]);
    for (int i = 0; i < wordsIn.size(); i++) begin
      frameBytes.push_back(wordsIn[i][15:8]);
      frameBytes.push_back(wordsIn[i][7:0]);
      expAddr.push_back(16'((int'(addr) + i) % 65536));
      expData.push_back(wordsIn[i]);
    end
    sum = 0;
    for (int i = 0; i < frameBytes.size(); i++) sum += int'(frameBytes[i]);
    csum = 8'((256 - (sum % 256)) % 256);
    if (corrupt) csum = csum + 8'd1;
    frameBytes.push_back(csum);
    expOk = !corrupt;
  endtask

  task automatic startFrame();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Send frameBytes[first .. first+count-1] with random idle gaps up to maxGap.
  task automatic applyStimulus(input int first, input int count, input int maxGap);
    int gap;
    bit taken;
    for (int i = first; i < first + count; i++) begin
      gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
      valid = 1'b0;
      repeat (gap) @(negedge clock);
      byteIn = frameBytes[i];
      valid = 1'b1;
      taken = 1'b0;
      for (int c = 0; c < 40 && !taken; c++) begin
        taken = (ready === 1'b1);
        @(negedge clock);
      end
      if (!taken) begin
        checkOutput($sformatf("byteAccept%0d", i), 32'd0, 32'd1);
        valid = 1'b0;
        return;
      end
    end
    valid = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    for (int c = 0; c < 20 && busy !== 1'b0; c++) @(negedge clock);
    if (busy !== 1'b0) checkOutput({tag, ".busyClear"}, 32'(busy), 32'd0);
  endtask

  task automatic checkFrame(input string tag, input int base, input int rBase);
    int got;
    got = gotAddr.size() - base;
    checkOutput({tag, ".writeCount"}, 32'(got), 32'(expAddr.size()));
    for (int i = 0; i < expAddr.size() && i < got; i++) begin
      checkOutput($sformatf("%s.addr%0d", tag, i), 32'(gotAddr[base + i]), 32'(expAddr[i]));
      checkOutput($sformatf("%s.data%0d", tag, i), 32'(gotData[base + i]), 32'(expData[i]));
    end
    checkOutput({tag, ".done"}, 32'(done), 32'(expOk));
    checkOutput({tag, ".error"}, 32'(error), 32'(!expOk));
    checkOutput({tag, ".halt"}, 32'(halt), 32'(!expOk));
    checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
    checkOutput({tag, ".readyInWrite"}, 32'(readyDuringWrite - rBase), 32'd0);
  endtask

  task automatic runFrame(input string tag, input int maxGap);
    int base;
    int rBase;
    base = gotAddr.size();
    rBase = readyDuringWrite;
    startFrame();
    applyStimulus(0, frameBytes.size(), maxGap);
    waitIdle(tag);
    checkFrame(tag, base, rBase);
  endtask

  task automatic setBasicWords();
    wordsIn.delete();
    wordsIn.push_back(16'h1234);
    wordsIn.push_back(16'hABCD);
  endtask

  initial begin
    int base;
    int rBase;
    int n;

    // Reset state.
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("reset.ready", 32'(ready), 32'd0);
    checkOutput("reset.write", 32'(memWrite), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.done", 32'(done), 32'd0);
    checkOutput("reset.error", 32'(error), 32'd0);
    checkOutput("reset.addr", 32'(memWaddr), 32'd0);
    checkOutput("reset.data", 32'(memWdata), 32'd0);
    checkOutput("reset.halt", 32'(halt), 32'd1);

    // A byte offered in IDLE is never accepted.
    byteIn = 8'hAA;
    valid = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("idle.ready", 32'(ready), 32'd0);
    checkOutput("idle.busy", 32'(busy), 32'd0);
    valid = 1'b0;

    // Directed frames.
    setBasicWords();
    buildFrame(16'h0010, 1'b0);
    runFrame("basic", 0);
    buildFrame(16'h0010, 1'b1);
    runFrame("badCsum", 0);
    wordsIn.delete();
    wordsIn.push_back(16'h0001);
    wordsIn.push_back(16'h0002);
    buildFrame(16'hFFFF, 1'b0);
    runFrame("wrap", 0);
    wordsIn.delete();
    buildFrame(16'h0000, 1'b0);
    runFrame("empty", 0);

    // Backpressure with idle gaps shorter than the timeout.
    setBasicWords();
    buildFrame(16'h0010, 1'b0);
    runFrame("gapBasic", 6);

    // Random frames against the model.
    for (int f = 0; f < 6; f++) begin
      n = int'($urandom_range(4, 0));
      wordsIn.delete();
      for (int i = 0; i < n; i++) wordsIn.push_back(16'($urandom));
      buildFrame(16'($urandom), $urandom_range(3, 0) == 0);
      runFrame($sformatf("rand%0d", f), 6);
    end

    // Timeout: stall after the count bytes.
    setBasicWords();
    buildFrame(16'h0010, 1'b0);
    base = gotAddr.size();
    startFrame();
    applyStimulus(0, 4, 0);
    repeat (12) @(negedge clock);
    checkOutput("timeout.error", 32'(error), 32'd1);
    checkOutput("timeout.done", 32'(done), 32'd0);
    checkOutput("timeout.halt", 32'(halt), 32'd1);
    checkOutput("timeout.busy", 32'(busy), 32'd0);
    checkOutput("timeout.writes", 32'(gotAddr.size() - base), 32'd0);

    // Start pulse in the middle of a frame is ignored.
    base = gotAddr.size();
    rBase = readyDuringWrite;
    startFrame();
    applyStimulus(0, 5, 0);
    startFrame();
    applyStimulus(5, frameBytes.size() - 5, 0);
    waitIdle("startIgnored");
    checkFrame("startIgnored", base, rBase);

    // Reset mid-frame after byte 5.
    base = gotAddr.size();
    startFrame();
    applyStimulus(0, 5, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    checkOutput("midReset.writes", 32'(gotAddr.size() - base), 32'd0);
    checkOutput("midReset.busy", 32'(busy), 32'd0);
    checkOutput("midReset.halt", 32'(halt), 32'd1);
    checkOutput("midReset.ready", 32'(ready), 32'd0);
    checkOutput("midReset.done", 32'(done), 32'd0);
    checkOutput("midReset.error", 32'(error), 32'd0);

    // A fresh frame after the reset loads normally.
    runFrame("afterReset", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
